// File: rtl/rrf_free_list_if.sv
// Dispatch-side bundle of the rename tag allocator: request/commit/flush in,
// grants and pointer state out.
interface rrf_free_list_if #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6
);
  logic [1:0]         req_num_i;
  logic               stall_i;
  logic [1:0]         com_num_i;
  logic               flush_i;
  logic               alloc0_en_o;
  logic [RRF_SEL-1:0] alloc0_tag_o;
  logic               alloc1_en_o;
  logic [RRF_SEL-1:0] alloc1_tag_o;
  logic               stall_dp_o;
  logic [RRF_SEL:0]   free_num_o;
  logic [RRF_SEL-1:0] rrfptr_o;
  logic               rrfcyc_o;
  logic [RRF_SEL-1:0] comptr_o;

  modport master (
    output req_num_i, stall_i, com_num_i, flush_i,
    input  alloc0_en_o, alloc0_tag_o, alloc1_en_o, alloc1_tag_o,
           stall_dp_o, free_num_o, rrfptr_o, rrfcyc_o, comptr_o
  );

  modport slave (
    input  req_num_i, stall_i, com_num_i, flush_i,
    output alloc0_en_o, alloc0_tag_o, alloc1_en_o, alloc1_tag_o,
           stall_dp_o, free_num_o, rrfptr_o, rrfcyc_o, comptr_o
  );
endinterface

// File: rtl/rrf_free_list.sv
// Circular rename-tag allocator: grants up to two consecutive Rrf entries per
// cycle, reclaims them in order at commit, and rewinds in one cycle on flush.
module rrf_free_list #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6
) (
  input  logic            clk,
  input  logic            reset,
  rrf_free_list_if.slave  bus
);
  localparam int W = RRF_SEL + 1;
  localparam logic [W-1:0] NUM_W = W'(RRF_NUM);

  logic [RRF_SEL-1:0] rrfptr;
  logic [RRF_SEL-1:0] comptr;
  logic               rrfcyc;
  logic               comcyc;
  logic [W-1:0]       free_num;

  logic [W-1:0] req_w;
  logic [W-1:0] com_raw;
  logic [W-1:0] com_w;
  logic [W-1:0] outstanding;
  logic [W-1:0] grant_w;
  logic [W-1:0] rrf_next;
  logic [W-1:0] com_next;

  always_comb begin
    req_w   = '0;
    com_raw = '0;
    if (bus.req_num_i == 2'd1 || bus.req_num_i == 2'd2) req_w = W'(bus.req_num_i);
    if (bus.com_num_i == 2'd1 || bus.com_num_i == 2'd2) com_raw = W'(bus.com_num_i);
    outstanding = NUM_W - free_num;
    com_w = (com_raw > outstanding) ? outstanding : com_raw;
    // Grant uses the registered count, so same-cycle commits cannot fund it.
    if (!reset && !bus.flush_i && !bus.stall_i && (free_num >= req_w))
      grant_w = req_w;
    else
      grant_w = '0;
    // Cycle bit sits above the pointer, so a plain add toggles it on wrap.
    rrf_next = {rrfcyc, rrfptr} + grant_w;
    com_next = {comcyc, comptr} + com_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rrfptr   <= '0;
      rrfcyc   <= 1'b0;
      comptr   <= '0;
      comcyc   <= 1'b0;
      free_num <= NUM_W;
    end else if (bus.flush_i) begin
      {comcyc, comptr} <= com_next;
      {rrfcyc, rrfptr} <= com_next;
      free_num         <= NUM_W;
    end else begin
      {comcyc, comptr} <= com_next;
      {rrfcyc, rrfptr} <= rrf_next;
      free_num         <= free_num + com_w - grant_w;
    end
  end

  assign bus.alloc0_en_o  = (grant_w != '0);
  assign bus.alloc1_en_o  = (grant_w == W'(2));
  assign bus.alloc0_tag_o = rrfptr;
  assign bus.alloc1_tag_o = rrfptr + RRF_SEL'(1);
  assign bus.stall_dp_o   = (req_w != '0) && (free_num < req_w) && !bus.flush_i && !reset;
  assign bus.free_num_o   = free_num;
  assign bus.rrfptr_o     = rrfptr;
  assign bus.rrfcyc_o     = rrfcyc;
  assign bus.comptr_o     = comptr;
endmodule

// File: tb/tb_rrf_free_list.sv
// Directed bench for rrf_free_list: grant, fill, wrap, commit/request overlap,
// flush, reset and illegal request/commit encodings.
module tb_rrf_free_list;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  rrf_free_list_if #(.RRF_NUM(64), .RRF_SEL(6)) bus ();

  rrf_free_list #(.RRF_NUM(64), .RRF_SEL(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic [1:0] req, input logic [1:0] com,
                        input logic stall, input logic flush);
    bus.req_num_i = req;
    bus.com_num_i = com;
    bus.stall_i   = stall;
    bus.flush_i   = flush;
  endtask

  // Inputs change 1 time unit after the rising edge; results are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(2'd2, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.alloc0_en_o !== 1'b0) begin errors++; $display("FAIL rst_en0 got %0b exp 0", bus.alloc0_en_o); end
    checks++; if (bus.stall_dp_o !== 1'b0) begin errors++; $display("FAIL rst_stall_dp got %0b exp 0", bus.stall_dp_o); end
    tick();
    reset = 1'b0;
    set_in(2'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.rrfptr_o !== 6'd0) begin errors++; $display("FAIL rst_rrfptr got %0d exp 0", bus.rrfptr_o); end
    checks++; if (bus.free_num_o !== 7'd64) begin errors++; $display("FAIL rst_free got %0d exp 64", bus.free_num_o); end
    checks++; if (bus.alloc1_tag_o !== 6'd1) begin errors++; $display("FAIL rst_tag1 got %0d exp 1", bus.alloc1_tag_o); end
    checks++; if (bus.comptr_o !== 6'd0 || bus.rrfcyc_o !== 1'b0) begin errors++; $display("FAIL rst_com_cyc got %0d/%0b exp 0/0", bus.comptr_o, bus.rrfcyc_o); end
  endtask

  task automatic test_basic_grant();
    set_in(2'd2, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if ({bus.alloc0_en_o, bus.alloc1_en_o} !== 2'b11) begin errors++; $display("FAIL basic_en got %b exp 11", {bus.alloc0_en_o, bus.alloc1_en_o}); end
    checks++; if (bus.alloc0_tag_o !== 6'd0 || bus.alloc1_tag_o !== 6'd1) begin errors++; $display("FAIL basic_tags got %0d,%0d exp 0,1", bus.alloc0_tag_o, bus.alloc1_tag_o); end
    tick();
    set_in(2'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.rrfptr_o !== 6'd2) begin errors++; $display("FAIL basic_rrfptr got %0d exp 2", bus.rrfptr_o); end
    checks++; if (bus.free_num_o !== 7'd62) begin errors++; $display("FAIL basic_free got %0d exp 62", bus.free_num_o); end
  endtask

  task automatic test_fill();
    set_in(2'd2, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 31; i++) tick();
    set_in(2'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.free_num_o !== 7'd0) begin errors++; $display("FAIL fill_free got %0d exp 0", bus.free_num_o); end
    checks++; if (bus.rrfptr_o !== 6'd0 || bus.rrfcyc_o !== 1'b1) begin errors++; $display("FAIL fill_ptr_cyc got %0d/%0b exp 0/1", bus.rrfptr_o, bus.rrfcyc_o); end
    set_in(2'd1, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.alloc0_en_o !== 1'b0 || bus.stall_dp_o !== 1'b1) begin errors++; $display("FAIL full_req en/stall got %0b/%0b exp 0/1", bus.alloc0_en_o, bus.stall_dp_o); end
    tick();
    set_in(2'd1, 2'd0, 1'b1, 1'b0);
    #1;
    checks++; if (bus.stall_dp_o !== 1'b1) begin errors++; $display("FAIL full_stall_indep got %0b exp 1", bus.stall_dp_o); end
    checks++; if (bus.free_num_o !== 7'd0 || bus.rrfptr_o !== 6'd0) begin errors++; $display("FAIL full_hold got %0d/%0d exp 0/0", bus.free_num_o, bus.rrfptr_o); end
    set_in(2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_commit_and_request();
    set_in(2'd0, 2'd1, 1'b0, 1'b0);
    tick();
    set_in(2'd2, 2'd2, 1'b0, 1'b0);
    #1;
    checks++; if (bus.free_num_o !== 7'd1) begin errors++; $display("FAIL cr_free1 got %0d exp 1", bus.free_num_o); end
    checks++; if (bus.alloc0_en_o !== 1'b0 || bus.stall_dp_o !== 1'b1) begin errors++; $display("FAIL cr_nogrant en/stall got %0b/%0b exp 0/1", bus.alloc0_en_o, bus.stall_dp_o); end
    tick();
    set_in(2'd2, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.free_num_o !== 7'd3 || bus.comptr_o !== 6'd3) begin errors++; $display("FAIL cr_free3 got %0d/%0d exp 3/3", bus.free_num_o, bus.comptr_o); end
    checks++; if ({bus.alloc0_en_o, bus.alloc1_en_o} !== 2'b11) begin errors++; $display("FAIL cr_grant got %b exp 11", {bus.alloc0_en_o, bus.alloc1_en_o}); end
    tick();
    set_in(2'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.free_num_o !== 7'd1 || bus.rrfptr_o !== 6'd2) begin errors++; $display("FAIL cr_after got %0d/%0d exp 1/2", bus.free_num_o, bus.rrfptr_o); end
  endtask

  task automatic test_wrap();
    set_in(2'd2, 2'd0, 1'b1, 1'b1);
    tick();
    set_in(2'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.rrfptr_o !== 6'd3 || bus.rrfcyc_o !== 1'b0 || bus.free_num_o !== 7'd64) begin errors++; $display("FAIL flush_rewind got %0d/%0b/%0d exp 3/0/64", bus.rrfptr_o, bus.rrfcyc_o, bus.free_num_o); end
    set_in(2'd2, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) tick();
    #1;
    checks++; if (bus.rrfptr_o !== 6'd63 || bus.free_num_o !== 7'd4) begin errors++; $display("FAIL wrap_pre got %0d/%0d exp 63/4", bus.rrfptr_o, bus.free_num_o); end
    checks++; if (bus.alloc0_tag_o !== 6'd63 || bus.alloc1_tag_o !== 6'd0 || bus.alloc1_en_o !== 1'b1) begin errors++; $display("FAIL wrap_tags got %0d,%0d en1 %0b exp 63,0 en1 1", bus.alloc0_tag_o, bus.alloc1_tag_o, bus.alloc1_en_o); end
    tick();
    set_in(2'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.rrfptr_o !== 6'd1 || bus.rrfcyc_o !== 1'b1 || bus.free_num_o !== 7'd2) begin errors++; $display("FAIL wrap_post got %0d/%0b/%0d exp 1/1/2", bus.rrfptr_o, bus.rrfcyc_o, bus.free_num_o); end
  endtask

  task automatic test_flush_commit();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_in(2'd2, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    set_in(2'd0, 2'd2, 1'b0, 1'b0);
    tick();
    tick();
    set_in(2'd2, 2'd2, 1'b0, 1'b1);
    #1;
    checks++; if (bus.free_num_o !== 7'd58 || bus.comptr_o !== 6'd4 || bus.rrfptr_o !== 6'd10) begin errors++; $display("FAIL fl_pre got %0d/%0d/%0d exp 58/4/10", bus.free_num_o, bus.comptr_o, bus.rrfptr_o); end
    checks++; if (bus.alloc0_en_o !== 1'b0 || bus.stall_dp_o !== 1'b0) begin errors++; $display("FAIL fl_nogrant en/stall got %0b/%0b exp 0/0", bus.alloc0_en_o, bus.stall_dp_o); end
    tick();
    set_in(2'd1, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.comptr_o !== 6'd6 || bus.rrfptr_o !== 6'd6 || bus.free_num_o !== 7'd64) begin errors++; $display("FAIL fl_post got %0d/%0d/%0d exp 6/6/64", bus.comptr_o, bus.rrfptr_o, bus.free_num_o); end
    checks++; if (bus.alloc0_en_o !== 1'b1 || bus.alloc0_tag_o !== 6'd6 || bus.alloc1_en_o !== 1'b0) begin errors++; $display("FAIL fl_next_tag got en %0b tag %0d en1 %0b exp 1 6 0", bus.alloc0_en_o, bus.alloc0_tag_o, bus.alloc1_en_o); end
    tick();
    set_in(2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    set_in(2'd3, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.alloc0_en_o !== 1'b0 || bus.stall_dp_o !== 1'b0) begin errors++; $display("FAIL req3 en/stall got %0b/%0b exp 0/0", bus.alloc0_en_o, bus.stall_dp_o); end
    tick();
    set_in(2'd0, 2'd3, 1'b0, 1'b0);
    tick();
    set_in(2'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.rrfptr_o !== 6'd7 || bus.free_num_o !== 7'd63 || bus.comptr_o !== 6'd6) begin errors++; $display("FAIL illegal_hold got %0d/%0d/%0d exp 7/63/6", bus.rrfptr_o, bus.free_num_o, bus.comptr_o); end
    set_in(2'd0, 2'd2, 1'b0, 1'b0);
    tick();
    #1;
    checks++; if (bus.free_num_o !== 7'd64 || bus.comptr_o !== 6'd7) begin errors++; $display("FAIL com_clamp got %0d/%0d exp 64/7", bus.free_num_o, bus.comptr_o); end
    tick();
    set_in(2'd2, 2'd0, 1'b1, 1'b0);
    #1;
    checks++; if (bus.free_num_o !== 7'd64 || bus.comptr_o !== 6'd7) begin errors++; $display("FAIL com_empty got %0d/%0d exp 64/7", bus.free_num_o, bus.comptr_o); end
    checks++; if (bus.alloc0_en_o !== 1'b0 || bus.stall_dp_o !== 1'b0) begin errors++; $display("FAIL stall_i en/stall_dp got %0b/%0b exp 0/0", bus.alloc0_en_o, bus.stall_dp_o); end
    tick();
    set_in(2'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.rrfptr_o !== 6'd7 || bus.free_num_o !== 7'd64) begin errors++; $display("FAIL stall_i_hold got %0d/%0d exp 7/64", bus.rrfptr_o, bus.free_num_o); end
  endtask

  task automatic test_reset_mid();
    set_in(2'd2, 2'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    set_in(2'd2, 2'd2, 1'b0, 1'b1);
    #1;
    checks++; if ({bus.alloc0_en_o, bus.alloc1_en_o, bus.stall_dp_o} !== 3'b000) begin errors++; $display("FAIL midrst_en got %b exp 000", {bus.alloc0_en_o, bus.alloc1_en_o, bus.stall_dp_o}); end
    tick();
    reset = 1'b0;
    set_in(2'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.rrfptr_o !== 6'd0 || bus.comptr_o !== 6'd0 || bus.rrfcyc_o !== 1'b0 || bus.free_num_o !== 7'd64) begin errors++; $display("FAIL midrst_state got %0d/%0d/%0b/%0d exp 0/0/0/64", bus.rrfptr_o, bus.comptr_o, bus.rrfcyc_o, bus.free_num_o); end
    checks++; if (bus.alloc0_tag_o !== 6'd0 || bus.alloc1_tag_o !== 6'd1) begin errors++; $display("FAIL midrst_tags got %0d,%0d exp 0,1", bus.alloc0_tag_o, bus.alloc1_tag_o); end
  endtask

  initial begin
    reset = 1'b1;
    set_in(2'd0, 2'd0, 1'b0, 1'b0);
    tick();
    test_reset();
    test_basic_grant();
    test_fill();
    test_commit_and_request();
    test_wrap();
    test_flush_commit();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rrf_free_list.md
# rrf_free_list

Rename-buffer tag allocator sitting directly upstream of the `Rrf` rename register file. Each cycle the dispatch stage requests zero, one or two destination tags, and this block grants consecutive `Rrf` entries from a circular pointer. It drives the `Rrf` allocate port(s) and tracks the retire pointer so entries are reclaimed in order at commit. On a branch-mispredict flush it discards all uncommitted allocations in one cycle.

## Interface
- `RRF_NUM`, default 64 (`RRF_NUM` in `Consts.v`): number of `Rrf` entries; power of two.
- `RRF_SEL`, default 6 (`RRF_SEL` in `Consts.v`): tag width, log2(`RRF_NUM`).

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `req_num_i`  in  2  tags requested this cycle: 0, 1 or 2; 3 treated as 0
- `stall_i`  in  1  downstream dispatch stall; no grant this cycle
- `com_num_i`  in  2  entries retired in order this cycle: 0, 1 or 2; 3 treated as 0
- `flush_i`  in  1  mispredict flush; discard all uncommitted allocations
- `alloc0_en_o`  out  1  first tag granted; drives `allocate_rrf_en_i`
- `alloc0_tag_o`  out  RRF_SEL  first granted tag (= `rrfptr_o`); drives `allocate_rrftag_i`
- `alloc1_en_o`  out  1  second tag granted
- `alloc1_tag_o`  out  RRF_SEL  second tag, (`rrfptr_o`+1) mod `RRF_NUM`
- `stall_dp_o`  out  1  request present but not enough free entries
- `free_num_o`  out  RRF_SEL+1  registered free-entry count, 0..`RRF_NUM`
- `rrfptr_o`  out  RRF_SEL  next tag to allocate
- `rrfcyc_o`  out  1  allocate-pointer wrap parity; toggles on each wrap
- `comptr_o`  out  RRF_SEL  oldest uncommitted tag

## Operation
- State registers: `rrfptr`, `rrfcyc`, `comptr`, `comcyc`, `free_num`.
- `req` = `req_num_i` if in {1,2}, else 0. `com` = `com_num_i` if in {1,2}, else 0. `com` is then clamped to `RRF_NUM` − `free_num`, so committing more than is outstanding is ignored.
- Grant is all-or-nothing. `grant` = `req` when `!reset && !flush_i && !stall_i && free_num >= req`; otherwise 0.
- `alloc0_en_o` = (`grant` >= 1). `alloc1_en_o` = (`grant` == 2).
- Tag outputs always show `rrfptr` and `rrfptr`+1 mod `RRF_NUM`, whether or not they are granted.
- `stall_dp_o` = `req` != 0 && `free_num` < `req` && !`flush_i` && !`reset`. It is independent of `stall_i`.
- Normal update, no flush:
  - `rrfptr` += `grant` mod `RRF_NUM`. `rrfcyc` toggles if the addition crosses `RRF_NUM`.
  - `comptr` += `com` mod `RRF_NUM`, with `comcyc` handled the same way.
  - `free_num` = `free_num` + `com` − `grant`.
- Commit and allocate in the same cycle both apply. Entries freed by the commit are not grantable until the next cycle, because the grant uses the registered `free_num`.
- Flush update: the commit in the flush cycle is honoured first.
  - `comptr`/`comcyc` advance by `com`.
  - `rrfptr`/`rrfcyc` are set to that advanced `comptr`/`comcyc`.
  - `free_num` = `RRF_NUM`.
  - No grant occurs.
- Invariant: `free_num` + (distance `comptr`→`rrfptr`, using the cycle bits) == `RRF_NUM`. When the pointers are equal: `rrfcyc` == `comcyc` means empty, `rrfcyc` != `comcyc` means full.

## Timing
- Reset values: `rrfptr_o`=0, `rrfcyc_o`=0, `comptr_o`=0, `free_num_o`=`RRF_NUM`, internal `comcyc`=0.
- During the reset cycle: all `*_en_o`=0 and `stall_dp_o`=0.
- Outputs after the reset edge: `alloc0_tag_o`=0, `alloc1_tag_o`=1.
- Grant is combinational, zero latency. `alloc*_en_o`/`alloc*_tag_o` are valid in the request cycle, and `Rrf` captures the allocation on the same rising edge.
- Pointer, count and cycle-bit outputs are registered and reflect that cycle's grant/commit/flush after the edge.
- Reset asserted mid-operation overrides flush, commit and request. The next state is the reset values.
- Flush overrides `stall_i` and `req_num_i`. Commit overrides nothing.
- Full: `free_num`=0, so every nonzero request stalls. Empty: `free_num`=`RRF_NUM`, so commits are clamped to 0.

## Test plan
1. **Basic grant.** After reset, `req_num_i`=2 for one cycle → `alloc0_en_o`=`alloc1_en_o`=1, tags 0 and 1. Next cycle `rrfptr_o`=2, `free_num_o`=62.
2. **Fill to full.** 32 consecutive cycles of `req_num_i`=2 → `free_num_o`=0, `rrfptr_o`=0, `rrfcyc_o`=1. Then `req_num_i`=1 → `alloc0_en_o`=0, `stall_dp_o`=1, and state does not change.
3. **Wrap across the boundary.** With `rrfptr_o`=63 and `free_num_o`>=2, `req_num_i`=2 → tags 63 and 0 granted. Next cycle `rrfptr_o`=1 and `rrfcyc_o` has toggled.
4. **Simultaneous commit and request.**
   - With `free_num_o`=1: `req_num_i`=2, `com_num_i`=2 → no grant, `stall_dp_o`=1. Next cycle `free_num_o`=3.
   - Then `req_num_i`=2 → granted, and the following cycle `free_num_o`=1.
5. **Flush with commit.** Allocate 10 tags (0–9), commit 4, then assert `flush_i` with `com_num_i`=2 and `req_num_i`=2 → no grant. Next cycle `comptr_o`=6, `rrfptr_o`=6, `free_num_o`=64; the next request gets tag 6.
6. **Reset and illegal inputs.**
   - `reset` asserted while `req_num_i`=2 → both enables 0, and next cycle all outputs are at reset values.
   - `req_num_i`=3 or `com_num_i`=3 → no state change.
   - `com_num_i`=2 when empty → `free_num_o` stays 64.
